rx_arbiter: RTL and testbench

Next-generation input stage of the NoC switch. It arbitrates between PORTS_NUM+1 input channels (PORTS_NUM neighbours plus the local port at index PORTS_NUM) and writes accepted flits into the output FIFO. Once a packet's head flit is accepted, the grant is locked to that channel until its tail flit has been accepted. Adds over the previous receiver:
- round-robin or fixed-priority modes
- one flit per cycle throughput, with no end-of-packet bubble
- an almost-full aware write path
- a stalled-packet watchdog
- status outputs

---
 rtl/noc_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/rx_arbiter.sv | 132 +++++++++++++
 tb/tb_rx_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit layout, arbitration modes and helpers for the NoC receiver
`timescale 1ns/1ps
package noc_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Flit layout is {data, last, addr}; addr sits at the bottom.
  localparam int ADDR_LSB = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  function automatic int last_bit(input int addr_size);
    return ADDR_LSB + addr_size;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin / fixed-priority request picker
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  input  logic         mode_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  logic [W-1:0] cand;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    cand    = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = N; k >= 1; k--) begin
      cand = mode_i ? W'(k - 1) : W'((int'(ptr_i) + k) % N);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
    gnt_o = valid_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/rx_arbiter.sv
// rtl/rx_arbiter.sv - NoC switch input stage: packet-locked arbitration into the output FIFO
`timescale 1ns/1ps
module rx_arbiter
  import noc_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int PORTS_NUM = 4,
  parameter int ARB_MODE  = 0,
  parameter int TIMEOUT   = 16,
  localparam int N        = PORTS_NUM + 1,
  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1,
  localparam int PORT_W   = clog2(N)
) (
  input  logic                  clk,
  input  logic                  a_rst,
  input  logic                  is_full,
  input  logic                  is_afull,
  input  logic [N-1:0]          wr_ready_in,
  input  logic [N*BUS_SIZE-1:0] data_i,
  output logic [N-1:0]          r_ready_out,
  output logic                  wr_req,
  output logic [BUS_SIZE-1:0]   data_o,
  output logic [PORT_W-1:0]     grant_port,
  output logic                  locked,
  output logic                  pkt_done,
  output logic                  err_timeout
);

  localparam int LAST_BIT = last_bit(ADDR_SIZE);
  localparam int CNT_W    = clog2(TIMEOUT + 2);

  state_e                state_q, state_d;
  logic [PORT_W-1:0]     grant_q, grant_d;
  logic [PORT_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_req_q, wr_req_d;
  logic [BUS_SIZE-1:0]   data_q, data_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  err_q, err_d;

  logic [N-1:0]          arb_gnt;
  logic [PORT_W-1:0]     arb_idx;
  logic                  arb_valid;
  logic                  can_wr;
  logic                  owner_valid;
  logic                  accept;
  logic [PORT_W-1:0]     sel_port;
  logic [BUS_SIZE-1:0]   sel_flit;

  rr_arbiter #(
    .N (N),
    .W (PORT_W)
  ) u_arb (
    .req_i   (wr_ready_in),
    .ptr_i   (ptr_q),
    .mode_i  (ARB_MODE == ARB_FIXED),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // A write issued last cycle may take the final free slot reported by is_afull.
  assign can_wr      = !is_full && !(wr_req_q && is_afull);
  assign owner_valid = wr_ready_in[grant_q];
  assign sel_port    = (state_q == ST_LOCK) ? grant_q : arb_idx;
  assign sel_flit    = data_i[sel_port*BUS_SIZE +: BUS_SIZE];
  assign accept      = can_wr && ((state_q == ST_LOCK) ? owner_valid : arb_valid);
  assign r_ready_out = accept ? (N'(1) << sel_port) : '0;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    wr_req_d   = accept;
    data_d     = data_q;
    pkt_done_d = 1'b0;
    err_d      = 1'b0;
    if (accept) begin
      data_d  = sel_flit;
      grant_d = sel_port;
      ptr_d   = sel_port;
      cnt_d   = '0;
      if (sel_flit[LAST_BIT]) begin
        state_d    = ST_IDLE;
        pkt_done_d = 1'b1;
      end else begin
        state_d = ST_LOCK;
      end
    end else if (state_q == ST_LOCK && TIMEOUT > 0 && !owner_valid) begin
      // Only a silent owner ages the lock; FIFO stalls never do.
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= PORT_W'(PORTS_NUM);
      ptr_q      <= PORT_W'(PORTS_NUM);
      cnt_q      <= '0;
      wr_req_q   <= 1'b0;
      data_q     <= '0;
      pkt_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      wr_req_q   <= wr_req_d;
      data_q     <= data_d;
      pkt_done_q <= pkt_done_d;
      err_q      <= err_d;
    end
  end

  assign wr_req      = wr_req_q;
  assign data_o      = data_q;
  assign grant_port  = grant_q;
  assign locked      = (state_q == ST_LOCK);
  assign pkt_done    = pkt_done_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_rx_arbiter.sv
// tb/tb_rx_arbiter.sv - self-checking bench for rx_arbiter (round-robin and fixed-priority instances)
`timescale 1ns/1ps
module tb_rx_arbiter;

  localparam int DS = 32;
  localparam int AS = 4;
  localparam int PN = 4;
  localparam int N  = PN + 1;
  localparam int BS = DS + AS + 1;
  localparam int PW = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          a_rst;
  logic          is_full;
  logic          is_afull;
  logic [N-1:0]  wr_ready_in;
  logic [N*BS-1:0] data_i;

  logic [N-1:0]  rr_rdy, fx_rdy;
  logic          rr_wr, fx_wr;
  logic [BS-1:0] rr_data, fx_data;
  logic [PW-1:0] rr_grant, fx_grant;
  logic          rr_locked, fx_locked, rr_done, fx_done, rr_err, fx_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rx_arbiter #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .PORTS_NUM(PN), .ARB_MODE(0), .TIMEOUT(TO)) dut_rr (
    .clk(clk), .a_rst(a_rst), .is_full(is_full), .is_afull(is_afull),
    .wr_ready_in(wr_ready_in), .data_i(data_i), .r_ready_out(rr_rdy),
    .wr_req(rr_wr), .data_o(rr_data), .grant_port(rr_grant), .locked(rr_locked),
    .pkt_done(rr_done), .err_timeout(rr_err)
  );

  rx_arbiter #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .PORTS_NUM(PN), .ARB_MODE(1), .TIMEOUT(TO)) dut_fx (
    .clk(clk), .a_rst(a_rst), .is_full(is_full), .is_afull(is_afull),
    .wr_ready_in(wr_ready_in), .data_i(data_i), .r_ready_out(fx_rdy),
    .wr_req(fx_wr), .data_o(fx_data), .grant_port(fx_grant), .locked(fx_locked),
    .pkt_done(fx_done), .err_timeout(fx_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BS-1:0] mk_flit(input int c, input logic last, input int tag);
    return {DS'(tag * 16 + c), last, AS'(c)};
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input int tag);
    wr_ready_in = v;
    for (int c = 0; c < N; c++) data_i[c*BS +: BS] = mk_flit(c, l[c], tag);
  endtask

  // Reference model: packet ownership, fairness pointer and idle-age counter.
  bit            m_locked, m_wr, m_done, m_err;
  int            m_grant, m_ptr, m_cnt;
  logic [BS-1:0] m_data;

  task automatic m_reset();
    m_locked = 0; m_wr = 0; m_done = 0; m_err = 0;
    m_grant = PN; m_ptr = PN; m_cnt = 0; m_data = '0;
  endtask

  function automatic int m_pick();
    if (is_full || (m_wr && is_afull)) return -1;
    if (m_locked) return wr_ready_in[m_grant] ? m_grant : -1;
    for (int k = 1; k <= N; k++) begin
      if (wr_ready_in[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic m_step(input int acc);
    logic [BS-1:0] f;
    m_done = 0; m_err = 0; m_wr = (acc >= 0);
    if (acc >= 0) begin
      f = data_i[acc*BS +: BS];
      m_data = f; m_grant = acc; m_ptr = acc; m_cnt = 0;
      m_locked = !f[AS];
      m_done = f[AS];
    end else if (m_locked && !wr_ready_in[m_grant]) begin
      m_cnt++;
      if (m_cnt == TO) begin
        m_locked = 0; m_err = 1; m_cnt = 0;
      end
    end
  endtask

  task automatic cycle_model();
    int acc;
    logic [N-1:0] e;
    @(negedge clk);
    acc = m_pick();
    e = '0;
    if (acc >= 0) e[acc] = 1'b1;
    chk("rnd_rdy", 64'(rr_rdy), 64'(e));
    @(posedge clk);
    m_step(acc);
    #1;
    chk("rnd_wr", 64'(rr_wr), 64'(m_wr));
    chk("rnd_data", 64'(rr_data), 64'(m_data));
    chk("rnd_grant", 64'(rr_grant), 64'(m_grant));
    chk("rnd_locked", 64'(rr_locked), 64'(m_locked));
    chk("rnd_done", 64'(rr_done), 64'(m_done));
    chk("rnd_err", 64'(rr_err), 64'(m_err));
  endtask

  task automatic do_reset();
    a_rst = 1'b1; is_full = 1'b0; is_afull = 1'b0;
    drive('0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic [N-1:0]  v;
    logic [N-1:0]  l;
    logic [N-1:0]  rdy;
    logic          wr;
    logic [PW-1:0] g;
    logic          lk;
    logic          dn;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [BS-1:0] fifo[$];
    int   idx, n;
    logic got;
    logic [13:0] bp_exp;
    int   vprob;

    // Round-robin sweep from reset, then a locked 3-flit packet with a competing channel.
    tbl.push_back('{5'b11111, 5'b11111, 5'b00001, 1'b1, 3'd0, 1'b0, 1'b1});
    tbl.push_back('{5'b11111, 5'b11111, 5'b00010, 1'b1, 3'd1, 1'b0, 1'b1});
    tbl.push_back('{5'b11111, 5'b11111, 5'b00100, 1'b1, 3'd2, 1'b0, 1'b1});
    tbl.push_back('{5'b11111, 5'b11111, 5'b01000, 1'b1, 3'd3, 1'b0, 1'b1});
    tbl.push_back('{5'b11111, 5'b11111, 5'b10000, 1'b1, 3'd4, 1'b0, 1'b1});
    tbl.push_back('{5'b11111, 5'b11111, 5'b00001, 1'b1, 3'd0, 1'b0, 1'b1});
    tbl.push_back('{5'b00010, 5'b00010, 5'b00010, 1'b1, 3'd1, 1'b0, 1'b1});
    tbl.push_back('{5'b00101, 5'b00000, 5'b00100, 1'b1, 3'd2, 1'b1, 1'b0});
    tbl.push_back('{5'b00101, 5'b00000, 5'b00100, 1'b1, 3'd2, 1'b1, 1'b0});
    tbl.push_back('{5'b00101, 5'b00100, 5'b00100, 1'b1, 3'd2, 1'b0, 1'b1});
    tbl.push_back('{5'b00001, 5'b00001, 5'b00001, 1'b1, 3'd0, 1'b0, 1'b1});
    tbl.push_back('{5'b00000, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0});

    a_rst = 1'b1; is_full = 1'b0; is_afull = 1'b0;
    drive('0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr", 64'(rr_wr), 64'(0));
    chk("rst_data", 64'(rr_data), 64'(0));
    chk("rst_grant", 64'(rr_grant), 64'(PN));
    chk("rst_locked", 64'(rr_locked), 64'(0));
    chk("rst_done", 64'(rr_done), 64'(0));
    chk("rst_err", 64'(rr_err), 64'(0));
    chk("rst_rdy", 64'(rr_rdy), 64'(0));
    a_rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].l, i);
      @(negedge clk);
      chk("tbl_rdy", 64'(rr_rdy), 64'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk("tbl_wr", 64'(rr_wr), 64'(tbl[i].wr));
      chk("tbl_grant", 64'(rr_grant), 64'(tbl[i].g));
      chk("tbl_locked", 64'(rr_locked), 64'(tbl[i].lk));
      chk("tbl_done", 64'(rr_done), 64'(tbl[i].dn));
      if (tbl[i].wr) chk("tbl_data", 64'(rr_data), 64'(mk_flit(int'(tbl[i].g), tbl[i].l[tbl[i].g], i)));
    end

    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(5'b11111, 5'b11111, i);
      @(negedge clk);
      chk("fx_rdy", 64'(fx_rdy), 64'(5'b00001));
      @(posedge clk);
      #1;
      chk("fx_grant", 64'(fx_grant), 64'(0));
      chk("fx_data", 64'(fx_data), 64'(mk_flit(0, 1'b1, i)));
    end

    // Backpressure: afull phase gives alternate accepts, full phase gives none.
    do_reset();
    bp_exp = 14'b11110000101011;
    idx = 0;
    fifo.delete();
    for (int cyc = 0; cyc < 14; cyc++) begin
      is_afull = (cyc >= 2 && cyc < 6);
      is_full  = (cyc >= 6 && cyc < 10);
      drive(5'b01000, (idx == 7) ? 5'b01000 : 5'b00000, idx);
      @(negedge clk);
      got = rr_rdy[3];
      chk("bp_rdy", 64'(rr_rdy), 64'(bp_exp[cyc] ? 5'b01000 : 5'b00000));
      @(posedge clk);
      if (got) idx++;
      #1;
      if (rr_wr) fifo.push_back(rr_data);
      chk("bp_err", 64'(rr_err), 64'(0));
    end
    is_full = 1'b0; is_afull = 1'b0;
    chk("bp_count", 64'(fifo.size()), 64'(8));
    for (int k = 0; k < 8; k++) begin
      if (k < fifo.size()) chk("bp_order", 64'(fifo[k]), 64'(mk_flit(3, k == 7, k)));
    end
    chk("bp_unlocked", 64'(rr_locked), 64'(0));

    // Watchdog: head-only packet from channel 1 while channel 3 waits.
    do_reset();
    drive(5'b00010, 5'b00000, 0);
    @(negedge clk);
    chk("wd_head_rdy", 64'(rr_rdy), 64'(5'b00010));
    @(posedge clk);
    #1;
    chk("wd_locked", 64'(rr_locked), 64'(1));
    drive(5'b01000, 5'b01000, 1);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (rr_err) begin
        n = k;
        break;
      end
    end
    chk("wd_cycles", 64'(n), 64'(16));
    chk("wd_released", 64'(rr_locked), 64'(0));
    @(negedge clk);
    chk("wd_next_rdy", 64'(rr_rdy), 64'(5'b01000));
    @(posedge clk);
    #1;
    chk("wd_next_grant", 64'(rr_grant), 64'(3));
    chk("wd_err_pulse", 64'(rr_err), 64'(0));
    chk("wd_next_done", 64'(rr_done), 64'(1));

    // Asynchronous reset mid-packet drops the lock without an error pulse.
    do_reset();
    drive(5'b00100, 5'b00000, 0);
    @(posedge clk);
    #1;
    chk("ar_locked", 64'(rr_locked), 64'(1));
    drive('0, '0, 0);
    #2;
    a_rst = 1'b1;
    #1;
    chk("ar_cleared", 64'(rr_locked), 64'(0));
    chk("ar_err", 64'(rr_err), 64'(0));
    chk("ar_grant", 64'(rr_grant), 64'(PN));
    @(posedge clk);
    #1;
    a_rst = 1'b0;

    do_reset();
    vprob = 50;
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) vprob = (($urandom_range(2) == 0) ? 8 : ($urandom_range(1) == 0) ? 50 : 90);
      is_full  = ($urandom_range(7) == 0);
      is_afull = ($urandom_range(3) == 0);
      begin
        logic [N-1:0] v, l;
        for (int c = 0; c < N; c++) begin
          v[c] = ($urandom_range(99) < vprob);
          l[c] = ($urandom_range(2) == 0);
        end
        drive(v, l, i);
      end
      cycle_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
